spi_master_shifter: RTL and testbench
=====================================

Name: spi_master_shifter

Overview:
- Parametrised SPI master word shifter; successor to the fixed 8-bit, mode-0 byte shifter on the SD-card path.
- Adds a runtime clock divider, all four CPOL/CPHA modes, and a configurable word width.
- Adds a valid/ready transmit handshake, a one-cycle receive strobe, and chip-select generation with optional back-to-back (CS held) transfers.
- Runs entirely in the system clock domain: SCLK is a registered output, not a derived clock.

Parameters:
- DATA_W, 8: bits per transfer word, >= 2.
- DIV_W, 8: width of the clk_div input.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- clk_div  in  DIV_W  SCLK half-period = clk_div+1 clocks; latched at word accept.
- cpol  in  1  SCLK idle level; latched at accept.
- cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge; latched at accept.
- cs_keep  in  1  hold cs_n low into the next word if one is accepted at end of HOLD.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  shifter can accept a word this cycle.
- tx_data  in  DATA_W  word to transmit.
- rx_valid  out  1  one-cycle strobe: rx_data updated.
- rx_data  out  DATA_W  last received word; held between strobes.
- busy  out  1  high whenever state != IDLE.
- sclk  out  1  SPI clock.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in.
- cs_n  out  1  chip select, active low.

Behaviour:
- Reset (sync): state=IDLE, sclk=0, cs_n=1, mosi=0, rx_valid=0, rx_data=0, tx_ready=0, busy=0, all counters 0.
  - Reset mid-transfer aborts the word: no rx_valid; cs_n=1 on the next edge.
- Tick: half-period counter runs only outside IDLE, counts 0..div_l (latched clk_div), and pulses tick at div_l, then wraps to 0.
  - clk_div=0 gives a tick every clock, so SCLK = clock/2.
- IDLE:
  - Outputs: sclk=cpol (live input), cs_n=1, tx_ready=1.
  - On tx_valid&tx_ready (accept): latch tx_data, clk_div, cpol, cpha; cs_n=0 next cycle; go to SETUP.
  - If cpha=0, mosi = first bit from the accept+1 cycle.
- SETUP: one half-period (CS-to-first-edge); on tick, go to SHIFT with edge counter e=0.
- SHIFT: each tick toggles sclk and increments e (0..2*DATA_W-1). Edge e is leading when e is even, trailing when e is odd.
  - cpha=0: sample miso on leading edges; shift mosi to the next bit on trailing edges, except the final edge.
  - cpha=1: drive mosi with the next bit on leading edges (the first leading edge presents the first bit); sample miso on trailing edges.
  - After edge 2*DATA_W-1, sclk = latched cpol; go to HOLD.
- HOLD: one half-period; on tick, rx_data <= sampled word and rx_valid=1 for exactly that one cycle.
  - In that same tick cycle, tx_ready = cs_keep.
  - If tx_valid&cs_keep: accept the new word (re-latch config), cs_n stays 0, go directly to SETUP.
  - Otherwise: cs_n=1, go to GAP.
- GAP: one half-period with cs_n=1 (minimum CS-high time), then IDLE.
- Latency: rx_valid asserts exactly (2*DATA_W+2)*(clk_div+1) clocks after the accept cycle.
- Bit order: MSB first (see Optional Feature).
- Changes to clk_div/cpol/cpha/cs_keep while busy have no effect on the current word; cs_keep is evaluated only in the HOLD tick cycle.
- tx_ready is 0 in SETUP, SHIFT, GAP, and in HOLD except at the tick cycle.
- mosi returns to 0 in GAP/IDLE.

Optional Feature:
- Macro: SPI_MASTER_LSB_FIRST_EN.
- When defined: an extra input port lsb_first (1 bit) is present, latched at accept.
  - lsb_first=1: transmit bit 0 first; received bits fill rx_data from bit 0 upward.
  - lsb_first=0: identical to the non-macro build.
- When undefined: the port is absent; always MSB first.
- Timing is identical in both builds.

Test Plan:
- Mode 0, clk_div=0, miso looped to mosi, send 0xA5 -> 8 rising sclk edges, rx_data=0xA5, rx_valid asserted exactly 18 clocks after accept; cs_n high 1 cycle later.
- Mode 3 (cpol=1, cpha=1), clk_div=3, slave model returns 0x3C while master sends 0xC3 -> sclk idles high; slave sees 0xC3; rx_data=0x3C; rx_valid 72 clocks after accept.
- Modes 1 and 2 with a loopback slave model, word 0x5A -> rx_data=0x5A; sample edge checked against cpha for each mode.
- cs_keep=1 with tx_valid held, words 0x12 then 0x34 -> cs_n stays low across both words; two rx_valid strobes 18 clocks apart (clk_div=0); then GAP, then IDLE.
- Reset asserted during SHIFT after 3 bits -> next cycle: cs_n=1, busy=0, no rx_valid, rx_data=0; the following accept transfers normally.
- With SPI_MASTER_LSB_FIRST_EN and lsb_first=1, loopback 0x01 -> first mosi bit is 1 and rx_data=0x01; with lsb_first=0, first mosi bit is 0.

Source files
------------

// File: rtl/spi_master_shifter.sv
// SPI master word shifter: runtime clock divider, all four CPOL/CPHA modes, valid/ready TX, RX strobe.
// Optional build macro SPI_MASTER_LSB_FIRST_EN adds the lsb_first input for LSB-first transfers.
`timescale 1ns/1ps

module spi_master_shifter #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              cs_keep,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic              cs_n
);

  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]        state;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_l;
  logic              cpol_l;
  logic              cpha_l;
  logic              lsb_l;
  logic              lsb_in;
  logic [EW-1:0]     edge_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_data_q;
  logic              sclk_q;
  logic              mosi_q;
  logic              cs_n_q;

  logic tick;
  logic hold_tick;
  logic shift_tick;
  logic leading;
  logic sample_now;
  logic drive_now;
  logic accept;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  assign tick       = (state != IDLE) && (div_cnt == div_l);
  assign hold_tick  = (state == HOLD) && tick;
  assign shift_tick = (state == SHIFT) && tick;
  assign leading    = ~edge_cnt[0];
  // cpha=0 samples on leading edges, cpha=1 on trailing edges; the other edge drives mosi.
  assign sample_now = shift_tick && (leading ^ cpha_l);
  assign drive_now  = shift_tick && (cpha_l ? leading : (!leading && edge_cnt != LAST_EDGE));

  assign tx_ready = !reset && ((state == IDLE) || (hold_tick && cs_keep));
  assign accept   = tx_valid && tx_ready;
  assign rx_valid = hold_tick && !reset;
  // The strobe cycle already presents the new word so a consumer can capture it with rx_valid.
  assign rx_data  = rx_valid ? rx_sr : rx_data_q;
  assign busy     = (state != IDLE);
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      div_l     <= '0;
      cpol_l    <= 1'b0;
      cpha_l    <= 1'b0;
      lsb_l     <= 1'b0;
      edge_cnt  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      div_cnt <= ((state == IDLE) || tick) ? '0 : div_cnt + 1'b1;
      if (hold_tick) rx_data_q <= rx_sr;

      if (accept) begin
        div_l    <= clk_div;
        cpol_l   <= cpol;
        cpha_l   <= cpha;
        lsb_l    <= lsb_in;
        sclk_q   <= cpol;
        cs_n_q   <= 1'b0;
        edge_cnt <= '0;
        rx_sr    <= '0;
        state    <= SETUP;
        // With cpha=0 the first bit must be on the wire before the first (sampling) edge.
        if (!cpha) begin
          mosi_q <= head_bit(tx_data, lsb_in);
          tx_sr  <= shift_word(tx_data, lsb_in);
        end else begin
          mosi_q <= 1'b0;
          tx_sr  <= tx_data;
        end
      end else begin
        case (state)
          IDLE: begin
            sclk_q <= cpol;
            cs_n_q <= 1'b1;
            mosi_q <= 1'b0;
          end
          SETUP: begin
            if (tick) begin
              edge_cnt <= '0;
              state    <= SHIFT;
            end
          end
          SHIFT: begin
            if (tick) begin
              sclk_q   <= ~sclk_q;
              edge_cnt <= edge_cnt + 1'b1;
              if (sample_now)
                rx_sr <= lsb_l ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
              if (drive_now) begin
                mosi_q <= head_bit(tx_sr, lsb_l);
                tx_sr  <= shift_word(tx_sr, lsb_l);
              end
              if (edge_cnt == LAST_EDGE) begin
                sclk_q <= cpol_l;
                state  <= HOLD;
              end
            end
          end
          HOLD: begin
            if (tick) begin
              cs_n_q <= 1'b1;
              mosi_q <= 1'b0;
              state  <= GAP;
            end
          end
          GAP: begin
            mosi_q <= 1'b0;
            if (tick) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Directed self-checking bench for spi_master_shifter: all four modes, divider, back-to-back CS, reset abort.
// Build with SPI_MASTER_LSB_FIRST_EN defined to also exercise the lsb_first option.
`timescale 1ns/1ps

module tb_spi_master_shifter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] clk_div = 8'd0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       cs_keep = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = 8'd0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;
  logic       lsb_first = 1'b0;

  int total = 0;
  int bad = 0;

  // Simple SPI slave model; loop_en instead feeds mosi straight back to miso.
  logic       loop_en = 1'b1;
  logic [7:0] s_load = 8'd0;
  logic       s_cpol = 1'b0;
  logic       s_cpha = 1'b0;
  logic [7:0] s_tx = 8'd0;
  logic [7:0] s_rx = 8'd0;
  logic       s_miso = 1'b0;
  logic       prev_sclk = 1'b0;
  logic       prev_cs = 1'b1;

  assign miso = loop_en ? mosi : s_miso;

  spi_master_shifter #(.DATA_W(8), .DIV_W(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .clk_div  (clk_div),
    .cpol     (cpol),
    .cpha     (cpha),
    .cs_keep  (cs_keep),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .cs_n     (cs_n)
  );

  always #5 clock = ~clock;

  always @(sclk or cs_n) begin
    if (prev_cs && !cs_n) begin
      s_rx = 8'd0;
      s_tx = s_load;
      if (!s_cpha) begin
        s_miso = s_tx[7];
        s_tx   = {s_tx[6:0], 1'b0};
      end
    end else if (!cs_n && (sclk !== prev_sclk)) begin
      if ((sclk != s_cpol) != s_cpha) s_rx = {s_rx[6:0], mosi};
      else begin
        s_miso = s_tx[7];
        s_tx   = {s_tx[6:0], 1'b0};
      end
    end
    prev_sclk = sclk;
    prev_cs   = cs_n;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Sets the transfer configuration, lets sclk settle at its idle level, then raises tx_valid.
  task automatic apply_stimulus(input logic [7:0] data, input logic [7:0] div, input logic pol,
                                input logic pha, input logic keep);
    tx_data = data;
    clk_div = div;
    cpol    = pol;
    cpha    = pha;
    cs_keep = keep;
    s_cpol  = pol;
    s_cpha  = pha;
    step();
    step();
    tx_valid = 1'b1;
  endtask

  task automatic run_word(input string tag, input logic [7:0] data, input logic [7:0] div,
                          input logic pol, input logic pha, input int exp_lat,
                          input logic [7:0] exp_rx, input logic [7:0] exp_slave,
                          input logic check_first, input logic exp_first);
    int n;
    int rises;
    logic prev;
    apply_stimulus(data, div, pol, pha, 1'b0);
    check_output({tag, " idle sclk"}, sclk, pol);
    check_output({tag, " idle tx_ready"}, tx_ready, 1'b1);
    step();
    tx_valid = 1'b0;
    check_output({tag, " cs_n low"}, cs_n, 1'b0);
    if (check_first) check_output({tag, " first mosi"}, mosi, exp_first);
    n = 1;
    rises = 0;
    prev = sclk;
    while (!rx_valid && n < 2000) begin
      step();
      n++;
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    check_output({tag, " latency"}, n, exp_lat);
    check_output({tag, " rx_data"}, rx_data, exp_rx);
    check_output({tag, " sclk rises"}, rises, 8);
    check_output({tag, " slave rx"}, s_rx, exp_slave);
    step();
    check_output({tag, " cs_n release"}, cs_n, 1'b1);
    check_output({tag, " rx_valid one cycle"}, rx_valid, 1'b0);
    n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
    check_output({tag, " back to idle"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    int strobes;
    logic cs_ok;

    $display("[TB] start");
    step();
    step();
    step();
    check_output("reset cs_n", cs_n, 1'b1);
    check_output("reset sclk", sclk, 1'b0);
    check_output("reset mosi", mosi, 1'b0);
    check_output("reset rx_valid", rx_valid, 1'b0);
    check_output("reset rx_data", rx_data, 8'h00);
    check_output("reset busy", busy, 1'b0);
    check_output("reset tx_ready", tx_ready, 1'b0);
    reset = 1'b0;
    step();
    check_output("post reset tx_ready", tx_ready, 1'b1);

    loop_en = 1'b1;
    run_word("mode0", 8'hA5, 8'd0, 1'b0, 1'b0, 18, 8'hA5, 8'hA5, 1'b1, 1'b1);

    loop_en = 1'b0;
    s_load  = 8'h3C;
    run_word("mode3", 8'hC3, 8'd3, 1'b1, 1'b1, 72, 8'h3C, 8'hC3, 1'b0, 1'b0);

    loop_en = 1'b1;
    run_word("mode1", 8'h5A, 8'd1, 1'b0, 1'b1, 36, 8'h5A, 8'h5A, 1'b0, 1'b0);
    run_word("mode2", 8'h5A, 8'd0, 1'b1, 1'b0, 18, 8'h5A, 8'h5A, 1'b1, 1'b0);

    $display("[TB] back-to-back words with cs_keep");
    apply_stimulus(8'h12, 8'd0, 1'b0, 1'b0, 1'b1);
    step();
    tx_data = 8'h34;
    n = 1;
    cs_ok = 1'b1;
    while (!rx_valid && n < 200) begin
      step();
      n++;
      if (cs_n !== 1'b0) cs_ok = 1'b0;
    end
    check_output("keep first latency", n, 18);
    check_output("keep first rx_data", rx_data, 8'h12);
    check_output("keep tx_ready at hold", tx_ready, 1'b1);
    step();
    tx_valid = 1'b0;
    cs_keep  = 1'b0;
    n = 1;
    while (!rx_valid && n < 200) begin
      if (cs_n !== 1'b0) cs_ok = 1'b0;
      step();
      n++;
    end
    check_output("keep strobe spacing", n, 18);
    check_output("keep second rx_data", rx_data, 8'h34);
    check_output("keep cs_n held low", cs_ok, 1'b1);
    step();
    check_output("keep gap cs_n", cs_n, 1'b1);
    check_output("keep gap busy", busy, 1'b1);
    step();
    check_output("keep idle busy", busy, 1'b0);
    check_output("keep idle tx_ready", tx_ready, 1'b1);

    $display("[TB] reset during shift");
    apply_stimulus(8'hFF, 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    tx_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check_output("abort mid shift busy", busy, 1'b1);
    reset = 1'b1;
    step();
    check_output("abort cs_n", cs_n, 1'b1);
    check_output("abort busy", busy, 1'b0);
    check_output("abort rx_valid", rx_valid, 1'b0);
    check_output("abort rx_data", rx_data, 8'h00);
    reset = 1'b0;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rx_valid) strobes++;
    end
    check_output("abort no strobe", strobes, 0);
    check_output("abort cs_n stays high", cs_n, 1'b1);
    run_word("after abort", 8'h81, 8'd0, 1'b0, 1'b0, 18, 8'h81, 8'h81, 1'b1, 1'b1);

`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_first = 1'b1;
    run_word("lsb first", 8'h01, 8'd0, 1'b0, 1'b0, 18, 8'h01, 8'h80, 1'b1, 1'b1);
    lsb_first = 1'b0;
    run_word("msb first", 8'h01, 8'd0, 1'b0, 1'b0, 18, 8'h01, 8'h01, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
